// File: rtl/cacheline_adaptor_if.sv
// Cacheline adaptor bus bundle.
// Cache side : line_i/address_i/read_i/write_i in, line_o/resp_o out.
// Memory side: burst_i/resp_i in, burst_o/address_o/read_o/write_o out.
// slave  = the adaptor's view, master = the cache+memory environment's view.
interface cacheline_adaptor_if #(
  parameter int s_line  = 256,
  parameter int s_burst = 64
);
  logic [s_line-1:0]  line_i;
  logic [s_line-1:0]  line_o;
  logic [31:0]        address_i;
  logic               read_i;
  logic               write_i;
  logic               resp_o;
  logic [s_burst-1:0] burst_i;
  logic [s_burst-1:0] burst_o;
  logic [31:0]        address_o;
  logic               read_o;
  logic               write_o;
  logic               resp_i;

  modport slave (
    input  line_i, address_i, read_i, write_i, burst_i, resp_i,
    output line_o, resp_o, burst_o, address_o, read_o, write_o
  );

  modport master (
    output line_i, address_i, read_i, write_i, burst_i, resp_i,
    input  line_o, resp_o, burst_o, address_o, read_o, write_o
  );
endinterface

// File: rtl/cacheline_adaptor.sv
// Cacheline adaptor: single-cycle s_line transfers on the cache side become
// n_beats-beat s_burst bursts on the memory side, and back.
// Ports:
//   clk - clock, rising edge
//   rst - asynchronous active-low reset
//   bus - cacheline_adaptor_if.slave (cache request/line, memory burst signals)
// All outputs are registered or decoded from registered state only.
module cacheline_adaptor #(
  parameter int s_line  = 256,
  parameter int s_burst = 64,
  parameter int n_beats = s_line / s_burst
) (
  input  logic                   clk,
  input  logic                   rst,
  cacheline_adaptor_if.slave     bus
);
  localparam int CW = $clog2(n_beats);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t            r_state, w_next;
  logic [CW-1:0]     r_cnt;
  logic [s_line-1:0] r_buf;
  logic [31:0]       r_addr;
  logic              w_last;

  // Handshake on the final beat closes the burst.
  assign w_last = bus.resp_i && (r_cnt == CW'(n_beats - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  if (bus.write_i)     w_next = WRITE;  // write wins a tie
             else if (bus.read_i) w_next = READ;
      READ:  if (w_last)          w_next = DONE;
      WRITE: if (w_last)          w_next = DONE;
      DONE:                       w_next = IDLE;
      default:                    w_next = IDLE;
    endcase
  end

  // Line buffer, beat counter and latched address. The counter wraps to 0
  // on the last beat, which is harmless since IDLE clears it anyway.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_buf  <= '0;
      r_cnt  <= '0;
      r_addr <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.write_i) begin
            r_buf  <= bus.line_i;
            r_addr <= {bus.address_i[31:5], 5'b0};
            r_cnt  <= '0;
          end else if (bus.read_i) begin
            r_addr <= {bus.address_i[31:5], 5'b0};
            r_cnt  <= '0;
          end
        end
        READ: begin
          if (bus.resp_i) begin
            r_buf[r_cnt*s_burst +: s_burst] <= bus.burst_i;
            r_cnt <= r_cnt + CW'(1);
          end
        end
        WRITE: begin
          if (bus.resp_i) r_cnt <= r_cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.read_o    = (r_state == READ);
  assign bus.write_o   = (r_state == WRITE);
  assign bus.resp_o    = (r_state == DONE);
  assign bus.address_o = r_addr;
  assign bus.line_o    = r_buf;
  // Tracks the counter, so it holds through resp_i gaps; zero after reset
  // because the buffer is cleared.
  assign bus.burst_o   = r_buf[r_cnt*s_burst +: s_burst];
endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed self-checking bench for cacheline_adaptor. Inputs change and
// outputs are sampled on the falling edge; the DUT acts on rising edges.
module tb_cacheline_adaptor;
  logic clk;
  logic rst;
  int   pass_cnt;
  int   total_cnt;

  cacheline_adaptor_if bus ();

  cacheline_adaptor dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  logic [63:0]  D0, D1, D2, D3;
  logic [255:0] wline;

  task automatic test_reset;
    rst = 1'b0;
    bus.line_i = '0; bus.address_i = '0; bus.read_i = 0; bus.write_i = 0;
    bus.burst_i = '0; bus.resp_i = 0;
    repeat (2) @(negedge clk);
    total_cnt++;
    if ({bus.read_o, bus.write_o, bus.resp_o} !== 3'b000)
      $display("FAIL reset_ctrl: got %b want 000", {bus.read_o, bus.write_o, bus.resp_o});
    else pass_cnt++;
    total_cnt++;
    if (bus.line_o !== 256'h0) $display("FAIL reset_line: got %h want 0", bus.line_o);
    else pass_cnt++;
    total_cnt++;
    if ({bus.address_o, bus.burst_o} !== 96'h0)
      $display("FAIL reset_addr_burst: got %h %h want 0 0", bus.address_o, bus.burst_o);
    else pass_cnt++;
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fill;
    logic [63:0] beats [4];
    beats[0] = 64'h1111111111111111; beats[1] = 64'h2222222222222222;
    beats[2] = 64'h3333333333333333; beats[3] = 64'h4444444444444444;
    bus.read_i = 1; bus.address_i = 32'h1234_567F;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) begin
        total_cnt++;
        if (bus.read_o !== 1'b1 || bus.write_o !== 1'b0)
          $display("FAIL fill_req: got rd=%b wr=%b want rd=1 wr=0", bus.read_o, bus.write_o);
        else pass_cnt++;
        total_cnt++;
        if (bus.address_o !== 32'h1234_5660)
          $display("FAIL fill_addr: got %h want 12345660", bus.address_o);
        else pass_cnt++;
      end
      total_cnt++;
      if (bus.resp_o !== 1'b0) $display("FAIL fill_early_resp c%0d: got %b want 0", c, bus.resp_o);
      else pass_cnt++;
      bus.resp_i = 1; bus.burst_i = beats[c-1];
    end
    @(negedge clk); // cycle 5
    bus.resp_i = 0; bus.read_i = 0;
    total_cnt++;
    if (bus.resp_o !== 1'b1 || bus.read_o !== 1'b0)
      $display("FAIL fill_done: got resp=%b rd=%b want resp=1 rd=0", bus.resp_o, bus.read_o);
    else pass_cnt++;
    total_cnt++;
    if (bus.line_o !== {beats[3], beats[2], beats[1], beats[0]})
      $display("FAIL fill_line: got %h want %h", bus.line_o, {beats[3], beats[2], beats[1], beats[0]});
    else pass_cnt++;
    total_cnt++;
    if (bus.address_o !== 32'h1234_5660)
      $display("FAIL fill_addr_done: got %h want 12345660", bus.address_o);
    else pass_cnt++;
    @(negedge clk); // cycle 6
    total_cnt++;
    if (bus.resp_o !== 1'b0) $display("FAIL fill_resp_width: got %b want 0", bus.resp_o);
    else pass_cnt++;
  endtask

  task automatic test_write_gaps;
    logic       pat  [7];
    logic [1:0] eidx [7];
    logic [63:0] dv [4];
    pat  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    eidx = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd3, 2'd3};
    dv[0] = D0; dv[1] = D1; dv[2] = D2; dv[3] = D3;
    bus.write_i = 1; bus.line_i = wline; bus.address_i = 32'h8000_0040;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      total_cnt++;
      if (bus.write_o !== 1'b1 || bus.resp_o !== 1'b0 || bus.burst_o !== dv[eidx[c-1]])
        $display("FAIL wr_beat c%0d: got wr=%b resp=%b burst=%h want wr=1 resp=0 burst=%h",
                 c, bus.write_o, bus.resp_o, bus.burst_o, dv[eidx[c-1]]);
      else pass_cnt++;
      bus.resp_i = pat[c-1];
    end
    @(negedge clk); // cycle 8
    bus.resp_i = 0; bus.write_i = 0;
    total_cnt++;
    if (bus.resp_o !== 1'b1 || bus.write_o !== 1'b0)
      $display("FAIL wr_done: got resp=%b wr=%b want resp=1 wr=0", bus.resp_o, bus.write_o);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (bus.resp_o !== 1'b0) $display("FAIL wr_resp_width: got %b want 0", bus.resp_o);
    else pass_cnt++;
  endtask

  task automatic test_simultaneous;
    logic [255:0] l;
    l = {D0, D1, D2, D3};
    bus.read_i = 1; bus.write_i = 1; bus.line_i = l; bus.address_i = 32'h0000_1020;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) begin
        total_cnt++;
        if (bus.write_o !== 1'b1 || bus.read_o !== 1'b0)
          $display("FAIL simul_pick: got wr=%b rd=%b want wr=1 rd=0", bus.write_o, bus.read_o);
        else pass_cnt++;
      end
      bus.resp_i = 1;
    end
    @(negedge clk);
    bus.resp_i = 0; bus.read_i = 0; bus.write_i = 0;
    total_cnt++;
    if (bus.resp_o !== 1'b1 || bus.line_o !== l)
      $display("FAIL simul_done: got resp=%b line=%h want resp=1 line=%h", bus.resp_o, bus.line_o, l);
    else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_stray;
    logic [255:0] l;
    l = {D0, D1, D2, D3};
    for (int c = 0; c < 3; c++) begin
      bus.resp_i = 1; bus.burst_i = 64'hDEAD_BEEF_DEAD_BEEF;
      @(negedge clk);
      total_cnt++;
      if ({bus.read_o, bus.write_o, bus.resp_o} !== 3'b000)
        $display("FAIL stray_ctrl c%0d: got %b want 000", c, {bus.read_o, bus.write_o, bus.resp_o});
      else pass_cnt++;
    end
    bus.resp_i = 0;
    total_cnt++;
    if (bus.line_o !== l) $display("FAIL stray_line: got %h want %h", bus.line_o, l);
    else pass_cnt++;
  endtask

  task automatic test_held;
    int nresp;
    logic [255:0] exp_l;
    nresp = 0;
    exp_l = {{8{8'h0A}}, {8{8'h09}}, {8{8'h08}}, {8{8'h07}}};
    bus.read_i = 1; bus.address_i = 32'h0000_0100;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (bus.resp_o === 1'b1) nresp++;
      if (c == 5 || c == 11) begin
        total_cnt++;
        if (bus.resp_o !== 1'b1) $display("FAIL held_resp c%0d: got %b want 1", c, bus.resp_o);
        else pass_cnt++;
      end
      if (c == 6) begin
        total_cnt++;
        if (bus.read_o !== 1'b0) $display("FAIL held_idle c6: got rd=%b want 0", bus.read_o);
        else pass_cnt++;
      end
      if (c == 7) begin
        total_cnt++;
        if (bus.read_o !== 1'b1) $display("FAIL held_restart c7: got rd=%b want 1", bus.read_o);
        else pass_cnt++;
      end
      if (c == 11) bus.read_i = 0;
      bus.resp_i  = ((c >= 1 && c <= 4) || (c >= 7 && c <= 10));
      bus.burst_i = {8{8'(c)}};
    end
    bus.resp_i = 0;
    total_cnt++;
    if (nresp != 2) $display("FAIL held_count: got %0d pulses want 2", nresp);
    else pass_cnt++;
    total_cnt++;
    if (bus.line_o !== exp_l) $display("FAIL held_line: got %h want %h", bus.line_o, exp_l);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    int nresp;
    nresp = 0;
    bus.read_i = 1; bus.address_i = 32'h0000_2000;
    @(negedge clk); bus.resp_i = 1; bus.burst_i = 64'hAAAA_AAAA_AAAA_AAAA;
    @(negedge clk); bus.resp_i = 1; bus.burst_i = 64'hBBBB_BBBB_BBBB_BBBB;
    @(negedge clk); bus.resp_i = 0;
    total_cnt++;
    if (bus.read_o !== 1'b1 || bus.line_o[127:0] !== {64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA})
      $display("FAIL rstmid_pre: got rd=%b low=%h want rd=1 low=bbbb..aaaa", bus.read_o, bus.line_o[127:0]);
    else pass_cnt++;
    #2 rst = 1'b0;
    #1;
    total_cnt++;
    if ({bus.read_o, bus.write_o, bus.resp_o} !== 3'b000)
      $display("FAIL rstmid_ctrl: got %b want 000", {bus.read_o, bus.write_o, bus.resp_o});
    else pass_cnt++;
    total_cnt++;
    if (bus.line_o !== 256'h0 || bus.address_o !== 32'h0 || bus.burst_o !== 64'h0)
      $display("FAIL rstmid_data: got line=%h addr=%h burst=%h want 0", bus.line_o, bus.address_o, bus.burst_o);
    else pass_cnt++;
    bus.read_i = 0;
    @(negedge clk); rst = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.resp_o === 1'b1 || bus.read_o === 1'b1) nresp++;
    end
    total_cnt++;
    if (nresp != 0) $display("FAIL rstmid_after: got %0d active cycles want 0", nresp);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt = 0; total_cnt = 0;
    D0 = 64'h0123_4567_89AB_CDEF; D1 = 64'hFEDC_BA98_7654_3210;
    D2 = 64'hA5A5_A5A5_5A5A_5A5A; D3 = 64'h0F0F_0F0F_F0F0_F0F0;
    wline = {D3, D2, D1, D0};
    test_reset();
    test_fill();
    test_write_gaps();
    test_simultaneous();
    test_stray();
    test_held();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/cacheline_adaptor.md
# cacheline_adaptor

Converts single-cycle 256-bit cacheline transfers from the cache datapath into four-beat 64-bit bursts to physical memory, and back. The cache side connects to the datapath's `pmem_address`, `pmem_wdata` and `pmem_rdata` ports; the memory side connects to the burst DRAM model/arbiter. It buffers one full line, counts beats, and returns a single-cycle completion pulse to the cache controller.

## Interface
Parameters:
- `s_line`, 256, cacheline width in bits.
- `s_burst`, 64, memory beat width in bits.
- `n_beats`, `s_line/s_burst` (4), beats per line; the beat counter is `$clog2(n_beats)` bits wide.

Ports:
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `line_i`  in  s_line  line to write back; the cache drives it from `pmem_wdata`.
- `line_o`  out  s_line  filled line; the cache consumes it as `pmem_rdata`.
- `address_i`  in  32  line address from the cache (`pmem_address`).
- `read_i`  in  1  line fill request; held high by the cache until `resp_o`.
- `write_i`  in  1  line write-back request; held high by the cache until `resp_o`.
- `resp_o`  out  1  one-cycle completion pulse.
- `burst_i`  in  s_burst  read beat from memory.
- `burst_o`  out  s_burst  write beat to memory.
- `address_o`  out  32  burst address; it is the latched `{address_i[31:5],5'b0}`.
- `read_o`  out  1  memory read request.
- `write_o`  out  1  memory write request.
- `resp_i`  in  1  memory beat handshake; each high cycle transfers one beat.

## Operation
- The FSM has four states: IDLE, READ, WRITE, DONE.
- **IDLE**
  - If `write_i` is high, the block latches `line_i` into the line buffer and latches the aligned `address_i` into `address_o`. It clears the beat counter and goes to WRITE.
  - Otherwise, if `read_i` is high, it latches the address, clears the counter and goes to READ.
  - If both are high, write wins. Read is not serviced until a later request.
  - `resp_i` is ignored in IDLE.
- **READ**
  - `read_o` is 1.
  - On each cycle with `resp_i`=1: `buffer[64*cnt +: 64] <= burst_i`, then `cnt++`.
  - On the beat where `cnt==n_beats-1`, the FSM goes to DONE.
- **WRITE**
  - `write_o` is 1.
  - `burst_o = buffer[64*cnt +: 64]`.
  - Each `resp_i`=1 cycle advances `cnt`.
  - On the last beat, the FSM goes to DONE.
- **DONE**
  - `resp_o` is 1 and `read_o`/`write_o` are 0.
  - Next state is always IDLE.
  - Requests are ignored in DONE; the cache drops its request in response to `resp_o`.
- Beat order is little-endian: beat k carries line bits [64k+63:64k].
- `line_o` is driven from the line buffer. After a fill it stays stable until the next READ or WRITE overwrites the buffer.
- Gaps are allowed: cycles with `resp_i`=0 inside READ/WRITE hold the counter and hold `burst_o`.
- `address_o` stays constant from the latch cycle through DONE.
- Reset at any time, including mid-burst:
  - State goes to IDLE and `cnt` to 0.
  - `read_o`, `write_o` and `resp_o` go to 0.
  - `address_o`, `line_o` and `burst_o` go to 0.
  - A partial burst is abandoned, with no `resp_o`.

## Timing
- All outputs are registered or decoded from registered state. There are no combinational paths from cache inputs to memory outputs.
- Request sampled high in IDLE at edge 0 → `read_o`/`write_o` high in cycle 1.
- Beats are accepted at the earliest in cycles 1–4.
- DONE (and `resp_o`) follows in the cycle after the 4th beat: cycle 5 at minimum latency.
- IDLE is re-entered in cycle 6. A request still high then starts a new transaction, with its first memory request in cycle 7.
- `read_o`/`write_o` drop in the same cycle that `resp_o` rises.
- `line_o` holds the full line by the cycle `resp_o` is high.
- `burst_o` for beat k is valid from the first cycle of WRITE (k=0), or from the cycle after beat k-1 was accepted.

## Test plan
- **Reset:** assert `rst`=0 mid-READ after 2 beats → `read_o`=`write_o`=`resp_o`=0 and `line_o`=0 immediately (asynchronously), with no `resp_o` after release.
- **Back-to-back fill:** `read_i`=1, `address_i`=0x1234_567F, memory returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 in consecutive cycles → `address_o`=0x1234_5660; `resp_o` high for exactly 1 cycle, 5 cycles after the request; `line_o`={0x44..44,0x33..33,0x22..22,0x11..11}.
- **Write-back with gaps:** `write_i`=1, `line_i`={D3,D2,D1,D0}, `resp_i` pattern 1,0,0,1,1,0,1 → `burst_o` sequence D0,D1,D1,D1,D2,D3,D3; `resp_o` the cycle after the 7th; `write_o` low in that cycle.
- **Simultaneous request:** `read_i`=`write_i`=1 in IDLE → WRITE taken (`write_o`=1, `read_o`=0).
- **Stray handshake:** `resp_i`=1 while in IDLE → no state change, no `resp_o`, `line_o` unchanged.
- **Held request:** hold `read_i` through DONE → exactly one `resp_o` per transaction; the second fill's `read_o` rises in cycle 7.
